// File: rtl/excess3_to_bcd_serial.sv
// Serial excess-3 to BCD decoder, one digit per clock, LS digit first.
// Flags illegal excess-3 codes per digit; valid/ready on both sides.
module excess3_to_bcd_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err,
    output logic                  err_any
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] word;
    logic [3:0]          code;
    logic [3:0]          bcd;
    logic                bad;

    assign in_ready = (state == IDLE) & ~rst;
    assign err_any  = |out_err;

    // Decode the digit currently selected by idx
    always_comb begin
        code = 4'(word >> {idx, 2'b00});
        bad  = (code < 4'd3) || (code > 4'd12);
        bcd  = bad ? 4'hF : (code - 4'd3);
    end

    // Control FSM with registered result, error flags and out_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        word    <= in_data;
                        out_err <= '0;
                        idx     <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    out_data[idx*4 +: 4] <= bcd;
                    out_err[idx]         <= bad;
                    if (idx == LAST) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
